// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-port register file with write bypass and pending scoreboard
// Reads are combinational; writes, issue marks and pend_cnt update on the rising clock edge.
module reg_file_sb #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NRD*$clog2(NREGS)-1:0]  rd_addr,
   output logic [NRD*XLEN-1:0]           rd_data,
   output logic [NRD-1:0]                rd_busy,
   input  logic                          wr_en,
   input  logic [$clog2(NREGS)-1:0]      wr_addr,
   input  logic [XLEN-1:0]               wr_data,
   input  logic                          iss_en,
   input  logic [$clog2(NREGS)-1:0]      iss_addr,
   output logic [$clog2(NREGS):0]        pend_cnt,
   output logic                          any_pend
);

   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] pending;
   logic             wr_ok;
   logic             iss_ok;
   logic             cnt_inc;
   logic             cnt_dec;

   assign wr_ok  = wr_en && (wr_addr != '0);
   assign iss_ok = iss_en && (iss_addr != '0);

   // A same-cycle issue to the written register keeps it pending, so no decrement then.
   assign cnt_inc = iss_ok && !pending[iss_addr];
   assign cnt_dec = wr_ok && pending[wr_addr] && !(iss_ok && (iss_addr == wr_addr));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
         end
         pending  <= '0;
         pend_cnt <= '0;
      end else begin
         if (wr_ok) begin
            regs[wr_addr] <= wr_data;
         end
         for (int r = 1; r < NREGS; r++) begin
            if (iss_ok && (iss_addr == AW'(r))) begin
               pending[r] <= 1'b1;
            end else if (wr_ok && (wr_addr == AW'(r))) begin
               pending[r] <= 1'b0;
            end
         end
         pend_cnt <= pend_cnt + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
      end
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         if (!rst && (rd_addr[i*AW +: AW] != '0)) begin
            if (wr_en && (wr_addr == rd_addr[i*AW +: AW])) begin
               rd_data[i*XLEN +: XLEN] = wr_data;
            end else begin
               rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
               rd_busy[i]              = pending[rd_addr[i*AW +: AW]];
            end
         end
      end
   end

   assign any_pend = (pend_cnt != '0);

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed self-checking bench for reg_file_sb
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
module tb_reg_file_sb;

   logic        clk;
   logic        rst;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        iss_en;
   logic [4:0]  iss_addr;
   logic [5:0]  pend_cnt;
   logic        any_pend;

   int          n_cmp;
   int          n_err;
   logic [31:0] val [32];

   reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .pend_cnt (pend_cnt),
      .any_pend (any_pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      rst      = 1'b1;
      rd_addr  = '0;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      iss_en   = 1'b0;
      iss_addr = '0;
      tick();
      tick();
      rd_addr = {5'd2, 5'd1};
      #2;
      chk("reset_rd_data", rd_data, 64'h0);
      chk("reset_rd_busy", 64'(rd_busy), 64'h0);
      chk("reset_pend_cnt", 64'(pend_cnt), 64'h0);
      chk("reset_any_pend", 64'(any_pend), 64'h0);
      tick();
      rst = 1'b0;

      // Test 1: fill with random data, then reset mid-cycle
      for (int r = 1; r < 32; r++) begin
         val[r]  = $urandom;
         wr_en   = 1'b1;
         wr_addr = 5'(r);
         wr_data = val[r];
         tick();
      end
      wr_en    = 1'b0;
      iss_en   = 1'b1;
      iss_addr = 5'd3;
      tick();
      iss_en  = 1'b0;
      rd_addr = {5'd31, 5'd1};
      #2;
      chk("fill_read", rd_data, {val[31], val[1]});
      chk("fill_pend_cnt", 64'(pend_cnt), 64'd1);
      chk("fill_any_pend", 64'(any_pend), 64'd1);
      wr_en   = 1'b1;
      wr_addr = 5'd1;
      wr_data = 32'hFFFF_0001;
      rd_addr = {5'd1, 5'd1};
      #1;
      chk("pre_rst_bypass", rd_data, {32'hFFFF_0001, 32'hFFFF_0001});
      rst = 1'b1;
      #1;
      chk("rst_rd_data_now", rd_data, 64'h0);
      chk("rst_pend_cnt_now", 64'(pend_cnt), 64'h0);
      chk("rst_any_pend_now", 64'(any_pend), 64'h0);
      tick();
      rst     = 1'b0;
      wr_en   = 1'b0;
      rd_addr = {5'd31, 5'd1};
      #2;
      chk("post_rst_read", rd_data, 64'h0);
      chk("post_rst_busy", 64'(rd_busy), 64'h0);

      // Test 2: x0 ignores writes and issues
      wr_en    = 1'b1;
      wr_addr  = 5'd0;
      wr_data  = 32'hDEAD_BEEF;
      iss_en   = 1'b1;
      iss_addr = 5'd0;
      rd_addr  = {5'd0, 5'd0};
      #2;
      chk("x0_bypass", rd_data, 64'h0);
      chk("x0_busy_same", 64'(rd_busy), 64'h0);
      tick();
      wr_en  = 1'b0;
      iss_en = 1'b0;
      #2;
      chk("x0_read", rd_data, 64'h0);
      chk("x0_busy", 64'(rd_busy), 64'h0);
      chk("x0_pend_cnt", 64'(pend_cnt), 64'h0);

      // Test 3: bypass
      wr_en   = 1'b1;
      wr_addr = 5'd5;
      wr_data = 32'h1;
      tick();
      wr_en   = 1'b0;
      rd_addr = {5'd5, 5'd5};
      #2;
      chk("x5_init", rd_data, {32'h1, 32'h1});
      wr_en   = 1'b1;
      wr_data = 32'h1234;
      #2;
      chk("bypass_same", rd_data, {32'h1234, 32'h1234});
      tick();
      wr_en = 1'b0;
      #2;
      chk("bypass_next", rd_data, {32'h1234, 32'h1234});
      chk("wr_nonpend_cnt", 64'(pend_cnt), 64'h0);

      // Test 4: scoreboard hazard and release
      iss_en   = 1'b1;
      iss_addr = 5'd7;
      rd_addr  = {5'd5, 5'd7};
      #2;
      chk("iss_busy_same", 64'(rd_busy), 64'h0);
      tick();
      iss_en = 1'b0;
      #2;
      chk("x7_busy", 64'(rd_busy), 64'b01);
      chk("x7_pend_cnt", 64'(pend_cnt), 64'd1);
      wr_en   = 1'b1;
      wr_addr = 5'd7;
      wr_data = 32'h77;
      #2;
      chk("x7_wb_busy", 64'(rd_busy), 64'b00);
      chk("x7_wb_data", rd_data, {32'h1234, 32'h77});
      tick();
      wr_en = 1'b0;
      #2;
      chk("x7_clear_cnt", 64'(pend_cnt), 64'd0);
      chk("x7_clear_busy", 64'(rd_busy), 64'b00);

      // Test 5: simultaneous issue and writeback to the same register
      iss_en   = 1'b1;
      iss_addr = 5'd9;
      tick();
      iss_addr = 5'd9;
      wr_en    = 1'b1;
      wr_addr  = 5'd9;
      wr_data  = 32'h99;
      rd_addr  = {5'd9, 5'd9};
      #2;
      chk("sim_busy_same", 64'(rd_busy), 64'b00);
      tick();
      iss_en = 1'b0;
      wr_en  = 1'b0;
      #2;
      chk("sim_busy_next", 64'(rd_busy), 64'b11);
      chk("sim_pend_cnt", 64'(pend_cnt), 64'd1);
      chk("sim_data", rd_data, {32'h99, 32'h99});
      // Issue x10 while x9 is written back: count holds at 1
      iss_en   = 1'b1;
      iss_addr = 5'd10;
      wr_en    = 1'b1;
      wr_addr  = 5'd9;
      wr_data  = 32'h9A;
      tick();
      iss_en  = 1'b0;
      wr_en   = 1'b0;
      rd_addr = {5'd10, 5'd9};
      #2;
      chk("swap_pend_cnt", 64'(pend_cnt), 64'd1);
      chk("swap_busy", 64'(rd_busy), 64'b10);
      wr_en   = 1'b1;
      wr_addr = 5'd10;
      wr_data = 32'hA;
      tick();
      wr_en = 1'b0;
      #2;
      chk("swap_clear_cnt", 64'(pend_cnt), 64'd0);

      // Test 6: mark every register pending, then write them all back
      for (int r = 1; r < 32; r++) begin
         iss_en   = 1'b1;
         iss_addr = 5'(r);
         tick();
      end
      iss_addr = 5'd31;
      tick();
      iss_en  = 1'b0;
      rd_addr = {5'd31, 5'd1};
      #2;
      chk("full_pend_cnt", 64'(pend_cnt), 64'd31);
      chk("full_any_pend", 64'(any_pend), 64'd1);
      chk("full_busy", 64'(rd_busy), 64'b11);
      for (int r = 1; r < 32; r++) begin
         wr_en   = 1'b1;
         wr_addr = 5'(r);
         wr_data = 32'(r * 3);
         tick();
         if (r == 16) begin
            #2;
            chk("half_pend_cnt", 64'(pend_cnt), 64'd15);
         end
      end
      wr_en = 1'b0;
      #2;
      chk("empty_pend_cnt", 64'(pend_cnt), 64'd0);
      chk("empty_any_pend", 64'(any_pend), 64'd0);
      chk("empty_busy", 64'(rd_busy), 64'b00);
      chk("empty_data", rd_data, {32'd93, 32'd3});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
